// File: rtl/dec_result_buffer.sv
// Decoder result FWFT FIFO with valid/ready output, saturating error counters and sticky overflow.
// Define DEC_BUF_DROP_UNCORRECTABLE_EN to count but not store results flagged uncorrectable (2/3).
module dec_result_buffer #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int AMBA_WORD          = 32,
    parameter int DEPTH              = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [MAX_CODEWORD_WIDTH-1:0] in_data,
    input  logic [1:0]                    in_num_of_errors,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
    output logic [1:0]                    out_num_of_errors,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    input  logic                          clr_stats,
    output logic [AMBA_WORD-1:0]          err_cnt_single,
    output logic [AMBA_WORD-1:0]          err_cnt_double
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = MAX_CODEWORD_WIDTH + 2;

    logic [EW-1:0]        r_mem [DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic                 r_overflow;
    logic [AMBA_WORD-1:0] r_cnt_single;
    logic [AMBA_WORD-1:0] r_cnt_double;

    logic          w_empty;
    logic          w_full;
    logic          w_accept;
    logic          w_store;
    logic          w_read;
    logic [EW-1:0] w_head;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_accept = in_valid && !w_full;
    assign w_read   = !w_empty && out_ready;

`ifdef DEC_BUF_DROP_UNCORRECTABLE_EN
    assign w_store  = w_accept && !in_num_of_errors[1];
`else
    assign w_store  = w_accept;
`endif

    assign w_head            = r_mem[r_rd_ptr[AW-1:0]];
    assign in_ready          = !w_full;
    assign out_valid         = !w_empty;
    assign out_data          = w_empty ? '0 : w_head[MAX_CODEWORD_WIDTH-1:0];
    assign out_num_of_errors = w_empty ? 2'd0 : w_head[EW-1 -: 2];
    assign count             = r_wr_ptr - r_rd_ptr;
    assign overflow          = r_overflow;
    assign err_cnt_single    = r_cnt_single;
    assign err_cnt_double    = r_cnt_double;

    always_ff @(posedge clk) begin
        if (w_store && !rst) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_num_of_errors, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Clear takes priority over any same-cycle set or increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_overflow   <= 1'b0;
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else begin
            if (in_valid && w_full) r_overflow <= 1'b1;
            if (w_accept && (in_num_of_errors == 2'd1) && (r_cnt_single != '1))
                r_cnt_single <= r_cnt_single + 1'b1;
            if (w_accept && in_num_of_errors[1] && (r_cnt_double != '1))
                r_cnt_double <= r_cnt_double + 1'b1;
        end
    end

endmodule

// File: tb/tb_dec_result_buffer.sv
// Randomized and directed bench for dec_result_buffer against a queue-based reference model.
module tb_dec_result_buffer;

    localparam int W     = 32;
    localparam int CW    = 5;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_num_of_errors = 2'd0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [1:0]    out_num_of_errors;
    logic [AW:0]   count;
    logic          overflow;
    logic          clr_stats = 1'b0;
    logic [CW-1:0] err_cnt_single;
    logic [CW-1:0] err_cnt_double;

    dec_result_buffer #(.MAX_CODEWORD_WIDTH(W), .AMBA_WORD(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_num_of_errors(in_num_of_errors),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_num_of_errors(out_num_of_errors),
        .count(count), .overflow(overflow), .clr_stats(clr_stats),
        .err_cnt_single(err_cnt_single), .err_cnt_double(err_cnt_double)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference state: queue of {flag, data}, sticky flag, saturating counts.
    logic [W+1:0]  m_q[$];
    bit            m_ovf = 1'b0;
    int            m_single = 0;
    int            m_double = 0;
    localparam int CMAX = (1 << CW) - 1;

    always @(posedge clk) begin
        bit full, acc, rd;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_single = 0;
            m_double = 0;
        end else begin
            full = (m_q.size() == DEPTH);
            acc  = in_valid && !full;
            rd   = (m_q.size() > 0) && out_ready;
            if (in_valid && full) m_ovf = 1'b1;
            if (rd) void'(m_q.pop_front());
            if (acc) begin
`ifdef DEC_BUF_DROP_UNCORRECTABLE_EN
                if (in_num_of_errors < 2) m_q.push_back({in_num_of_errors, in_data});
`else
                m_q.push_back({in_num_of_errors, in_data});
`endif
                if (in_num_of_errors == 1 && m_single < CMAX) m_single++;
                if (in_num_of_errors >= 2 && m_double < CMAX) m_double++;
            end
            if (clr_stats) begin
                m_ovf = 1'b0;
                m_single = 0;
                m_double = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  64'(in_ready),  64'(m_q.size() < DEPTH));
            check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            check("out_data",  64'(out_data),  m_q.size() > 0 ? 64'(m_q[0][W-1:0]) : 64'd0);
            check("out_flag",  64'(out_num_of_errors), m_q.size() > 0 ? 64'(m_q[0][W+1:W]) : 64'd0);
            check("count",     64'(count),     64'(m_q.size()));
            check("overflow",  64'(overflow),  64'(m_ovf));
            check("cnt_single", 64'(err_cnt_single), 64'(m_single));
            check("cnt_double", 64'(err_cnt_double), 64'(m_double));
        end
    end

    // Drive one cycle's inputs, then wait to the following sampling point.
    task automatic cyc(input bit v, input logic [W-1:0] d, input logic [1:0] f,
                       input bit ordy, input bit clr, input bit r);
        in_valid = v;
        in_data = d;
        in_num_of_errors = f;
        out_ready = ordy;
        clr_stats = clr;
        rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        check("lit_reset_in_ready", 64'(in_ready), 64'd1);
        check("lit_reset_out_valid", 64'(out_valid), 64'd0);
        check("lit_reset_count", 64'(count), 64'd0);

        cyc(1, 32'hA, 0, 0, 0, 0);
        check("lit_first_data", 64'(out_data), 64'hA);
        check("lit_first_count", 64'(count), 64'd1);
        cyc(0, 0, 0, 1, 0, 0);
        check("lit_pop_empty", 64'(out_valid), 64'd0);

        for (int i = 1; i <= 5; i++) cyc(1, W'(i), 0, 0, 0, 0);
        check("lit_full_count", 64'(count), 64'd4);
        check("lit_full_in_ready", 64'(in_ready), 64'd0);
        check("lit_overflow", 64'(overflow), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("lit_drain_order", 64'(out_data), 64'(i));
            cyc(0, 0, 0, 1, 0, 0);
        end
        check("lit_drained", 64'(count), 64'd0);

        for (int i = 0; i < 4; i++) cyc(1, W'(32'h10 + i), 0, 0, 0, 0);
        cyc(1, 32'h99, 0, 1, 0, 0);
        check("lit_full_rw_count", 64'(count), 64'd3);
        check("lit_full_rw_head", 64'(out_data), 64'h11);
        for (int i = 0; i < 8; i++) cyc(1, W'(32'h20 + i), 0, (i % 2) == 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 0);

        cyc(0, 0, 0, 1, 1, 0);
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 2, 1, 1, 0, 0);
        cyc(1, 3, 2, 1, 0, 0);
        cyc(1, 4, 3, 1, 0, 0);
        cyc(1, 5, 0, 1, 0, 0);
        check("lit_single2", 64'(err_cnt_single), 64'd2);
        check("lit_double2", 64'(err_cnt_double), 64'd2);
        cyc(1, 6, 1, 1, 1, 0);
        check("lit_clr_wins", 64'(err_cnt_single), 64'd0);
        for (int i = 0; i < CMAX + 2; i++) cyc(1, W'(i), 1, 1, 0, 0);
        check("lit_saturate", 64'(err_cnt_single), 64'(CMAX));

        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, W'(32'h40 + i), 0, 0, 0, 0);
        cyc(1, 32'h55, 1, 1, 0, 1);
        check("lit_rst_count", 64'(count), 64'd0);
        check("lit_rst_out_valid", 64'(out_valid), 64'd0);
        check("lit_rst_overflow", 64'(overflow), 64'd0);
`ifdef DEC_BUF_DROP_UNCORRECTABLE_EN
        cyc(1, 32'h77, 2, 0, 0, 0);
        check("lit_drop_count", 64'(count), 64'd0);
        check("lit_drop_double", 64'(err_cnt_double), 64'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
                $urandom_range(0, 400) == 0);
        end
        cyc(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dec_result_buffer.md
Name: dec_result_buffer

Overview:
Downstream stage of the decoder. Captures each decoded info word (already stripped of parity and zero-padded) with its 2-bit num_of_errors flag into a small first-word-fall-through FIFO. Presents the entries to the register/bus side over a valid/ready handshake. Keeps saturating error statistics and a sticky overflow flag for software.

Parameters:
MAX_CODEWORD_WIDTH, 32, width of the decoded data word (matches the decoder data_out)
AMBA_WORD, 32, width of the statistics counters
DEPTH, 4, number of FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  decoder result present this cycle
in_data  in  MAX_CODEWORD_WIDTH  decoded info word
in_num_of_errors  in  2  0=clean, 1=single corrected, 2=uncorrectable, 3=reserved
in_ready  out  1  buffer can accept; equals !full
out_valid  out  1  head entry valid; equals !empty
out_ready  in  1  consumer takes head entry
out_data  out  MAX_CODEWORD_WIDTH  head data; 0 when out_valid=0
out_num_of_errors  out  2  head flag; 0 when out_valid=0
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; result offered while full
clr_stats  in  1  clears overflow and both counters
err_cnt_single  out  AMBA_WORD  accepted entries with flag 1, saturating
err_cnt_double  out  AMBA_WORD  accepted entries with flag 2 or 3, saturating

Behaviour:
- Reset (rst=1 at a clk edge): rd/wr pointers=0, count=0, overflow=0, both counters=0. Therefore in_ready=1, out_valid=0, out_data=0, out_num_of_errors=0. Storage array is not reset. Reset mid-operation discards all entries; any handshake in that cycle is ignored.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit. empty = pointers equal. full = index bits equal and wrap bits differ.
- Write: in_valid && in_ready stores {in_num_of_errors, in_data} at wr_ptr; wr_ptr increments.
- Read: out_valid && out_ready advances rd_ptr. Head is read combinationally from storage (FWFT).
- Latency: an entry accepted at edge N is visible at out_valid/out_data after edge N; 1 cycle when empty. No same-cycle passthrough.
- in_ready depends only on registered state. It does not depend on out_ready.
- Full + out_ready + in_valid: the read happens and the write is refused (in_ready=0); overflow sets. in_ready returns to 1 the next cycle.
- Empty + in_valid + out_ready: the write happens, no read; out_valid=1 the next cycle.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- overflow: set when in_valid && !in_ready; held until clr_stats or rst.
- Counters: increment on an accepted write with the matching flag. A counter holds at all-ones once saturated. Flag 0 increments neither counter.
- clr_stats is applied in the same cycle as a set or increment: clear wins; that cycle's event is lost. clr_stats does not touch FIFO contents.
- Pointer wrap: the DEPTH+1-th write wraps the index to 0 and toggles the wrap bit.

Optional Feature:
DEC_BUF_DROP_UNCORRECTABLE_EN
- Defined: an accepted result with flag 2 or 3 is not written to the FIFO. The pointer and count are unchanged, but err_cnt_double still increments. in_ready is unaffected. When full, a flag-2 offer still sets overflow.
- Not defined: all accepted results are stored regardless of flag.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, out_data=0, count=0, counters=0, overflow=0.
- Write 0x0000000A/flag 0 with out_ready=0 -> next cycle out_valid=1, out_data=0x0000000A, out_num_of_errors=0, count=1. Pulse out_ready -> out_valid=0.
- Write 5 entries 1..5 with out_ready=0, DEPTH=4 -> entries 1-4 accepted, in_ready=0 after the 4th, overflow=1. Drain -> data 1,2,3,4 in order; count reaches 0.
- Full FIFO, in_valid=1 and out_ready=1 together -> head popped, new word refused, count=3 next cycle. Then refill and drain 8 more words -> wrap-around order preserved.
- Flags 1,1,2,3,0 written -> err_cnt_single=2, err_cnt_double=2. clr_stats with a flag-1 write in the same cycle -> err_cnt_single=0. Force a counter to 0xFFFFFFFF plus one more event -> it stays 0xFFFFFFFF.
- rst asserted with 3 entries held and in_valid=1 -> next cycle count=0, out_valid=0, overflow=0. With DEC_BUF_DROP_UNCORRECTABLE_EN, write flag 2 -> count stays 0, err_cnt_double=1.
